// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: latches a payload on accept, then walks start, data
// (LSB first), optional parity and stop, one frame bit per CLK cycle.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Handshake: Data_Valid is a one-sided strobe; the implicit ready is !busy.
  // A strobe with busy=1 is dropped, so upstream must hold off until busy=0.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    case (state_q)
      S_IDLE: begin
        if (Data_Valid) begin
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          cnt_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: state_d = S_DATA;
      S_DATA: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mux_sel = 2'b00;
    case (state_q)
      S_START:  mux_sel = 2'b01;
      S_DATA:   mux_sel = 2'b10;
      S_PARITY: mux_sel = 2'b11;
      default:  mux_sel = 2'b00;
    endcase
  end

  assign ser_data = shift_q[0];
  assign par_bit  = par_bit_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: per-cycle expected frame vectors are queued
// and compared at the falling edge, where outputs are stable.
module tb_uart_tx_fsm;

  localparam int W = 5; // {busy, mux_sel[1:0], ser_data, par_bit}

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected vectors for one frame plus the IDLE cycle that follows it.
  task automatic push_frame(input logic [7:0] d, input logic pen, input logic par);
    exp_q.push_back({1'b1, 2'b01, 1'b0, par});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 2'b10, d[i], par});
    if (pen) exp_q.push_back({1'b1, 2'b11, 1'b0, par});
    exp_q.push_back({1'b1, 2'b00, 1'b0, par});
    exp_q.push_back({1'b0, 2'b00, 1'b0, par});
  endtask

  // Driver: presents a payload for exactly one accepting edge.
  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1 Data_Valid = 1'b0;
  endtask

  function automatic logic [W-1:0] observe(input logic [W-1:0] e);
    return {busy, mux_sel, (e[3:2] == 2'b10) ? ser_data : 1'b0, par_bit};
  endfunction

  task automatic test_reset();
    RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      total++;
      if ({busy, mux_sel, ser_data, par_bit} !== 5'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=00000", c, {busy, mux_sel, ser_data, par_bit});
      end
    end
    RST = 1'b0; Data_Valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      total++;
      if ({busy, mux_sel, ser_data, par_bit} !== 5'b0) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got=%b want=00000", c, {busy, mux_sel, ser_data, par_bit});
      end
    end
  endtask

  task automatic test_even_parity();
    logic [W-1:0] e;
    int idx = 0;
    push_frame(8'hA5, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      total++;
      if (observe(e) !== e) begin
        bad++;
        $display("FAIL even_a5 cyc=%0d got=%b want=%b", idx, observe(e), e);
      end
      idx++;
    end
  endtask

  task automatic test_odd_no_parity();
    logic [W-1:0] e;
    int idx = 0;
    push_frame(8'h07, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      total++;
      if (observe(e) !== e) begin
        bad++;
        $display("FAIL odd_nopar_07 cyc=%0d got=%b want=%b", idx, observe(e), e);
      end
      idx++;
    end
  endtask

  task automatic test_ignored_strobe();
    logic [W-1:0] e;
    int idx = 0;
    push_frame(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 2'b00, 1'b0, 1'b1});
    send(8'h00, 1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      total++;
      if (observe(e) !== e) begin
        bad++;
        $display("FAIL ignored_strobe cyc=%0d got=%b want=%b", idx, observe(e), e);
      end
      if (idx == 4) begin
        P_DATA = 8'hFF; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      end else if (idx == 5) begin
        Data_Valid = 1'b0;
      end
      idx++;
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] e;
    push_frame(8'h3C, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    for (int idx = 0; idx < 10; idx++) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      total++;
      if (observe(e) !== e) begin
        bad++;
        $display("FAIL mid_reset_pre cyc=%0d got=%b want=%b", idx, observe(e), e);
      end
      if (idx == 9) RST = 1'b1;
    end
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    total++;
    if ({busy, mux_sel, ser_data, par_bit} !== 5'b0) begin
      bad++;
      $display("FAIL mid_reset_idle got=%b want=00000", {busy, mux_sel, ser_data, par_bit});
    end
    push_frame(8'h3C, 1'b1, 1'b1);
    send(8'h3C, 1'b1, 1'b1);
    for (int idx = 0; exp_q.size() > 0; idx++) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      total++;
      if (observe(e) !== e) begin
        bad++;
        $display("FAIL mid_reset_after cyc=%0d got=%b want=%b", idx, observe(e), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    int idx = 0;
    push_frame(8'h01, 1'b1, 1'b1);
    push_frame(8'h80, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) exp_q.push_back({1'b0, 2'b00, 1'b0, 1'b1});
    @(negedge CLK);
    P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(posedge CLK);
    #1 P_DATA = 8'h80;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      total++;
      if (observe(e) !== e) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", idx, observe(e), e);
      end
      if (idx == 12) begin
        Data_Valid = 1'b0;
        P_DATA = 8'($urandom_range(0, 255));
      end
      idx++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_even_parity();
    test_odd_no_parity();
    test_ignored_strobe();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
